// File: rtl/sigmoid_pwl_pkg.sv
// Shared constants, PWL slope/intercept ROMs and lane helper for the sigmoid pipe.
// Tables cover |x| in [0, 8.0) in 32 segments of 0.25, Q8 output; knots are exact.
package sigmoid_pwl_pkg;

  localparam int DATA_LEN = 16;
  localparam int FRAC_LEN = 8;
  localparam int SEG_BITS = 5;
  localparam int LANES    = 4;
  localparam int COEF_LEN = 16;

  localparam int SH       = FRAC_LEN + 3 - SEG_BITS;
  localparam int SEG_N    = 1 << SEG_BITS;
  localparam int PROD_LEN = COEF_LEN + SH;

  typedef logic [DATA_LEN-1:0] data_t;
  typedef logic [COEF_LEN-1:0] coef_t;

  localparam data_t SAT_LIMIT = data_t'(8 << FRAC_LEN);
  localparam data_t ONE       = data_t'(1 << FRAC_LEN);
  localparam data_t HALF      = data_t'(1 << (FRAC_LEN - 1));
  localparam data_t MIN_VAL   = data_t'(1 << (DATA_LEN - 1));
  localparam data_t MAG_MAX   = data_t'((1 << (DATA_LEN - 1)) - 1);

  // slope = 4 * (icpt[k+1] - icpt[k]) so interpolation lands on the next knot
  localparam coef_t SLOPE_ROM [SEG_N] = '{
    16'd64, 16'd60, 16'd60, 16'd52, 16'd48, 16'd40, 16'd36, 16'd28,
    16'd28, 16'd20, 16'd16, 16'd12, 16'd8,  16'd8,  16'd8,  16'd4,
    16'd4,  16'd4,  16'd4,  16'd0,  16'd4,  16'd0,  16'd0,  16'd0,
    16'd4,  16'd0,  16'd0,  16'd0,  16'd0,  16'd0,  16'd0,  16'd0
  };

  localparam coef_t ICPT_ROM [SEG_N] = '{
    16'd128, 16'd144, 16'd159, 16'd174, 16'd187, 16'd199, 16'd209, 16'd218,
    16'd225, 16'd232, 16'd237, 16'd241, 16'd244, 16'd246, 16'd248, 16'd250,
    16'd251, 16'd252, 16'd253, 16'd254, 16'd254, 16'd255, 16'd255, 16'd255,
    16'd255, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256, 16'd256
  };

  function automatic data_t lane_slice(input logic [LANES*DATA_LEN-1:0] bus, input int idx);
    return bus[idx*DATA_LEN +: DATA_LEN];
  endfunction

endpackage

// File: rtl/sigmoid_pwl_lane.sv
// One lane of the PWL sigmoid datapath: |x|/sat, ROM lookup, interpolate/clamp/mirror.
// Three enabled register stages; optional tanh path under SIGMOID_TANH_MODE_EN.
module sigmoid_pwl_lane
  import sigmoid_pwl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
`ifdef SIGMOID_TANH_MODE_EN
  input  logic  mode,
`endif
  input  data_t x,
  output data_t y
);

  data_t a_c;

  always_comb begin
    if (!x[DATA_LEN-1])    a_c = x;
    else if (x == MIN_VAL) a_c = MAG_MAX;
    else                   a_c = -x;
`ifdef SIGMOID_TANH_MODE_EN
    // tanh(x) = 2*sigmoid(2x) - 1, so feed the table with 2|x|
    if (mode) a_c = a_c[DATA_LEN-2] ? MAG_MAX : {a_c[DATA_LEN-2:0], 1'b0};
`endif
  end

  logic                     s0_sign, s0_sat;
  logic [SH+SEG_BITS-1:0]   s0_a;
  logic                     s1_sign, s1_sat;
  coef_t                    s1_slope, s1_icpt;
  logic [SH-1:0]            s1_d;
`ifdef SIGMOID_TANH_MODE_EN
  logic                     s0_mode, s1_mode;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_sign  <= 1'b0;
      s0_sat   <= 1'b0;
      s0_a     <= '0;
      s1_sign  <= 1'b0;
      s1_sat   <= 1'b0;
      s1_slope <= '0;
      s1_icpt  <= '0;
      s1_d     <= '0;
`ifdef SIGMOID_TANH_MODE_EN
      s0_mode  <= 1'b0;
      s1_mode  <= 1'b0;
`endif
    end else if (en) begin
      s0_sign  <= x[DATA_LEN-1];
      s0_sat   <= (a_c >= SAT_LIMIT);
      s0_a     <= a_c[SH+SEG_BITS-1:0];
      s1_sign  <= s0_sign;
      s1_sat   <= s0_sat;
      s1_slope <= SLOPE_ROM[s0_a[SH +: SEG_BITS]];
      s1_icpt  <= ICPT_ROM[s0_a[SH +: SEG_BITS]];
      s1_d     <= s0_a[SH-1:0];
`ifdef SIGMOID_TANH_MODE_EN
      s0_mode  <= mode;
      s1_mode  <= s0_mode;
`endif
    end
  end

  typedef logic [COEF_LEN:0] sum_t;

  logic [PROD_LEN-1:0] prod;
  sum_t                yp;
  data_t               yc, ys, y_n;

  always_comb begin
    prod = PROD_LEN'(s1_slope) * PROD_LEN'(s1_d);
    yp   = {1'b0, s1_icpt} + sum_t'(prod >> FRAC_LEN);
    if (s1_sat || yp > sum_t'(ONE)) yc = ONE;
    else if (yp < sum_t'(HALF))     yc = HALF;
    else                            yc = data_t'(yp);
    ys  = s1_sign ? ONE - yc : yc;
    y_n = ys;
`ifdef SIGMOID_TANH_MODE_EN
    if (s1_mode) y_n = (ys << 1) - ONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)     y <= '0;
    else if (en) y <= y_n;
  end

endmodule

// File: rtl/sigmoid_pwl_pipe.sv
// Multi-lane 3-stage PWL sigmoid with valid/ready; all stages advance together.
// SIGMOID_TANH_MODE_EN adds a per-beat mode input selecting tanh instead of sigmoid.
module sigmoid_pwl_pipe
  import sigmoid_pwl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_LEN-1:0] in_data,
`ifdef SIGMOID_TANH_MODE_EN
  input  logic                      mode,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_LEN-1:0] out_data
);

  logic [2:0] vld;
  logic       adv;

  assign adv       = out_ready | ~vld[2];
  assign in_ready  = adv;
  assign out_valid = vld[2];

  always_ff @(posedge clk) begin
    if (rst)      vld <= '0;
    else if (adv) vld <= {vld[1:0], in_valid};
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    data_t x_l, y_l;
    assign x_l = lane_slice(in_data, i);

    sigmoid_pwl_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (adv),
`ifdef SIGMOID_TANH_MODE_EN
      .mode (mode),
`endif
      .x    (x_l),
      .y    (y_l)
    );

    assign out_data[i*DATA_LEN +: DATA_LEN] = y_l;
  end

endmodule

// File: doc/sigmoid_pwl_pipe.md
Name: sigmoid_pwl_pipe

Overview:
Multi-lane, pipelined, fixed-point sigmoid unit for the axiline datapath. It replaces the single-lane, combinational, step-LUT sigmoid with piecewise-linear (PWL) interpolation. Table size is halved by exploiting the symmetry sigmoid(-x) = 1 - sigmoid(x). It sits between the dot-product/accumulate stage and the gradient/update stage, and uses a valid/ready handshake on both sides.

Parameters:
DATA_LEN, 16, two's-complement width of each lane's input and output
FRAC_LEN, 8, fractional bits; 1.0 = 1<<FRAC_LEN
SEG_BITS, 5, log2 of PWL segment count over |x| in [0, 8.0); must satisfy SEG_BITS <= FRAC_LEN+3
LANES, 4, parallel independent lanes
COEF_LEN, 16, width of the unsigned slope and intercept table entries (Q.FRAC_LEN)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block accepts a beat this cycle
in_data  input  LANES*DATA_LEN  lane i occupies bits [i*DATA_LEN +: DATA_LEN]
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the beat
out_data  output  LANES*DATA_LEN  per-lane results, same packing as in_data

Behaviour:
- Reset and sampling: one clock (clk); reset rst is synchronous and active-high. rst is sampled on the rising edge of clk.
- Reset values: all stage valid bits 0, out_valid=0, out_data=0. in_ready is combinational and therefore reads 1 once rst deasserts.
- Pipeline: 3 register stages; latency is 3 cycles from accepted beat to out_valid with no backpressure; throughput is 1 beat/cycle.
- Advance enable: adv = out_ready | ~out_valid. in_ready = adv. All stages shift together when adv=1 and hold when adv=0. A bubble (valid=0) propagates as a bubble.
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer when out_valid & out_ready. While out_valid=1 and out_ready=0, out_data is held stable.
- S0 (per lane): register sign s = x[msb].
  - Compute a = |x|; x = -2^(DATA_LEN-1) maps to a = 2^(DATA_LEN-1)-1.
  - sat = (a >= 8<<FRAC_LEN).
- S1: define SH = FRAC_LEN+3-SEG_BITS.
  - seg = a >> SH (SEG_BITS bits, valid only when sat=0).
  - d = a & ((1<<SH)-1).
  - Read slope[seg] and icpt[seg] from constant ROMs.
- S2: if sat, yp = 1<<FRAC_LEN.
  - Otherwise yp = icpt[seg] + ((slope[seg]*d) >> FRAC_LEN): unsigned, truncating, product width COEF_LEN+SH.
  - Clamp yp to [1<<(FRAC_LEN-1), 1<<FRAC_LEN].
  - y = s ? (1<<FRAC_LEN) - yp : yp, zero-extended to DATA_LEN.
  - Output range is always [0, 1<<FRAC_LEN].
- Exact points: x = 0 gives exactly 1<<(FRAC_LEN-1). Symmetry is exact: y(x) + y(-x) = 1<<FRAC_LEN for every x except x = -2^(DATA_LEN-1).
- Boundaries:
  - |x| = 8.0 exactly counts as saturated.
  - Lanes are fully independent; no cross-lane state.
  - rst mid-stream discards all in-flight beats with no output transfer; the first beat after reset behaves identically to a cold start.
- Simultaneous transfers: an output transfer and an input transfer in the same cycle are both legal. With continuous valid and ready, there is no bubble.

Optional Feature:
SIGMOID_TANH_MODE_EN
- Defined:
  - Adds port mode (input, 1 bit), sampled with the input beat and carried down the pipe.
  - mode=1 computes tanh(x) = 2*sigmoid(2x) - 1: S0 doubles a, saturating at 2^(DATA_LEN-1)-1, before sat/seg; S2 outputs (y<<1) - (1<<FRAC_LEN), signed, in range [-1.0, +1.0].
  - mode=0 behaves as the base sigmoid.
  - Latency is unchanged.
- Undefined: no mode port; sigmoid only.

Decomposition:
- Package sigmoid_pwl_pkg holds:
  - the generated slope/intercept ROM constants, indexed by seg (produced by the existing table generator for the FRAC_LEN/SEG_BITS pair);
  - the SAT_LIMIT = 8<<FRAC_LEN and ONE = 1<<FRAC_LEN constants;
  - the lane-slice helper.
- One sub-module is natural: sigmoid_pwl_lane (datapath stages S0–S2 for one lane, taking an enable input), instantiated LANES times.
- Valid/advance control lives in the top level and is shared by all lanes.

Test Plan:
- Defaults: in_data all lanes 0x0000, out_ready=1 -> after 3 cycles out_valid=1, every lane = 0x0080 (0.5).
- Lanes {0x0900, 0xF700, 0x8000, 0x7FFF} (9.0, -9.0, min, max) -> {0x0100, 0x0000, 0x0000, 0x0100}.
- Lanes {0x0100, 0xFF00} (±1.0) -> sum exactly 0x0100; lane0 within ±2 LSB of 187 (0.7311).
- Stream 10 beats, out_ready toggling 1,0,0,1,... -> output order preserved, no loss or duplication; out_data stable while stalled; in_ready=0 only while out_valid=1 and out_ready=0.
- rst asserted for one cycle with 3 beats in flight -> out_valid=0 on the following cycle, out_data=0, no stale beat emitted afterwards.
- SIGMOID_TANH_MODE_EN, mode=1: inputs 0x0000 / 0x0900 / 0xF700 -> 0x0000 / 0x0100 / 0xFF00.
